// File: rtl/rf_wb_ctrl_pkg.sv
// Shared types and constants for the RF write-back controller.
// Build option RF_WB_FWD_EN (see rf_wb_ctrl.sv) does not affect this file.
package rf_wb_pkg;
   localparam int AW    = 9;
   localparam int DW    = 32;
   localparam int TID_W = 4;
   localparam int REG_W = 5;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          kill;
   } wb_entry_t;

   // RF address is thread id in the upper bits, register index below
   function automatic logic [AW-1:0] rf_addr_f(input logic [TID_W-1:0] tid,
                                               input logic [REG_W-1:0] rnum);
      return {tid, rnum};
   endfunction
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bus bundle between the execute/load pipes and the write-back controller.
// With RF_WB_FWD_EN defined the bundle also carries fwd_v/fwd_data.
interface rf_wb_ctrl_if
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          alu_wr_v;
   logic [AW-1:0] alu_wr_addr;
   logic [DW-1:0] alu_wr_data;
   logic          ld_wr_v;
   logic          ld_wr_rdy;
   logic [AW-1:0] ld_wr_addr;
   logic [DW-1:0] ld_wr_data;
   logic [AW-1:0] chk_addr;
   logic          chk_pend;
   logic          rf_we;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic [CW-1:0] fifo_cnt;
`ifdef RF_WB_FWD_EN
   logic          fwd_v;
   logic [DW-1:0] fwd_data;
`endif

   modport master (
      output alu_wr_v, alu_wr_addr, alu_wr_data,
      output ld_wr_v, ld_wr_addr, ld_wr_data, chk_addr,
      input  ld_wr_rdy, chk_pend, rf_we, rf_addr, rf_data, fifo_cnt
`ifdef RF_WB_FWD_EN
      , input fwd_v, fwd_data
`endif
   );

   modport slave (
      input  alu_wr_v, alu_wr_addr, alu_wr_data,
      input  ld_wr_v, ld_wr_addr, ld_wr_data, chk_addr,
      output ld_wr_rdy, chk_pend, rf_we, rf_addr, rf_data, fifo_cnt
`ifdef RF_WB_FWD_EN
      , output fwd_v, fwd_data
`endif
   );
endinterface

// File: rtl/rf_wb_ctrl_fifo.sv
// Load-return queue: circular buffer with per-entry kill-by-address and a
// parallel address match over live (valid, unkilled) entries.
module rf_wb_fifo
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic          clka,
   input  logic          rstn,
   input  logic          push,
   input  wb_entry_t     push_entry,
   input  logic          pop,
   input  logic          kill_v,
   input  logic [AW-1:0] kill_addr,
   input  logic [AW-1:0] match_addr,
   output wb_entry_t     head,
   output logic [CW-1:0] cnt,
   output logic          match
);
   wb_entry_t        mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;

   always_ff @(posedge clka) begin
      if (!rstn) begin
         vld    <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (kill_v && vld[i] && (mem[i].addr == kill_addr))
               mem[i].kill <= 1'b1;
         end
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= rd_ptr + 1'b1;
         end
         // push after pop so a full-and-wrapping slot ends up valid
         if (push) begin
            mem[wr_ptr] <= push_entry;
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         cnt <= cnt + CW'(push) - CW'(pop);
      end
   end

   assign head = mem[rd_ptr];

   always_comb begin
      match = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && !mem[i].kill && (mem[i].addr == match_addr))
            match = 1'b1;
      end
   end
endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back arbiter owning the RF write port: ALU first, then queued loads,
// then load bypass. Define RF_WB_FWD_EN to add the fwd_v/fwd_data outputs.
module rf_wb_ctrl
   import rf_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic         clka,
   input  logic         rstn,
   rf_wb_ctrl_if.slave  bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   wb_entry_t     head;
   wb_entry_t     push_e;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          empty;
   logic          ld_acc;
   logic          push;
   logic          pop;
   logic          fifo_hit;
   logic          out_hit;
   logic          rdy_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] data_q;

   assign empty   = (cnt == '0);
   assign ld_acc  = bus.ld_wr_v && rdy_q;
   assign pop     = !bus.alu_wr_v && !empty;
   // a load only skips the queue when nothing else wants the port
   assign push    = ld_acc && (bus.alu_wr_v || !empty);
   assign push_e  = '{addr: bus.ld_wr_addr, data: bus.ld_wr_data, kill: 1'b0};
   assign cnt_nxt = cnt + CW'(push) - CW'(pop);

   rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clka       (clka),
      .rstn       (rstn),
      .push       (push),
      .push_entry (push_e),
      .pop        (pop),
      .kill_v     (bus.alu_wr_v),
      .kill_addr  (bus.alu_wr_addr),
      .match_addr (bus.chk_addr),
      .head       (head),
      .cnt        (cnt),
      .match      (fifo_hit)
   );

   always_ff @(posedge clka) begin
      if (!rstn) begin
         rdy_q  <= 1'b0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
      end else begin
         rdy_q <= (cnt_nxt < CW'(DEPTH));
         if (bus.alu_wr_v) begin
            we_q   <= 1'b1;
            addr_q <= bus.alu_wr_addr;
            data_q <= bus.alu_wr_data;
         end else if (!empty) begin
            we_q   <= !head.kill;
            addr_q <= head.addr;
            data_q <= head.data;
         end else if (ld_acc) begin
            we_q   <= 1'b1;
            addr_q <= bus.ld_wr_addr;
            data_q <= bus.ld_wr_data;
         end else begin
            we_q   <= 1'b0;
         end
      end
   end

   assign out_hit       = we_q && (addr_q == bus.chk_addr);
   assign bus.ld_wr_rdy = rdy_q;
   assign bus.rf_we     = we_q;
   assign bus.rf_addr   = addr_q;
   assign bus.rf_data   = data_q;
   assign bus.fifo_cnt  = cnt;

`ifdef RF_WB_FWD_EN
   assign bus.chk_pend  = fifo_hit;
   assign bus.fwd_v     = out_hit;
   assign bus.fwd_data  = out_hit ? data_q : '0;
`else
   // RF read port has no write bypass, so the in-flight write still counts
   assign bus.chk_pend  = fifo_hit || out_hit;
`endif
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Write-back controller that sits directly upstream of the 512x32 thread register file (16 threads x 32 regs) and owns its write port.
- Merges two write-back sources into the single RF write port: the ALU (never stalls) and load-return (valid/ready).
- Queues load returns in a small FIFO and squashes stale queued loads overwritten by younger ALU writes.
- Reports pending-write hazards so the issue stage can stall reads.

Parameters:
AW, 9, RF address width ({tid[3:0], reg[4:0]})
DW, 32, data width
DEPTH, 4, load FIFO entries (power of 2, >=2)

Ports:
clka  in  1  clock
rstn  in  1  reset
alu_wr_v  in  1  ALU write-back valid (always accepted)
alu_wr_addr  in  AW  ALU destination
alu_wr_data  in  DW  ALU result
ld_wr_v  in  1  load-return valid
ld_wr_rdy  out  1  load-return ready
ld_wr_addr  in  AW  load destination
ld_wr_data  in  DW  load data
chk_addr  in  AW  hazard query address
chk_pend  out  1  query address has an unretired write (combinational)
rf_we  out  1  RF write enable
rf_addr  out  AW  RF write address
rf_data  out  DW  RF write data
fifo_cnt  out  clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: rstn is synchronous, active-low, on clka. While low, all FIFO entries are discarded, count=0, rf_we=0, rf_addr=0, rf_data=0, ld_wr_rdy=0, fifo_cnt=0. Reset mid-operation drops queued writes with no RF write.
- ld_wr_rdy is registered: it is 1 when count<DEPTH at the end of the previous cycle, and first rises the cycle after rstn deasserts. It is 0 when full, even if a pop occurs that cycle.
- Output stage: rf_we/rf_addr/rf_data are registered, so the RF write occurs one cycle after selection.
- Selection priority each cycle:
  1. alu_wr_v: the ALU write is selected.
  2. Otherwise, if the FIFO is non-empty: pop the head. rf_we=kill ? 0 : 1.
  3. Otherwise, if the load is accepted: bypass with no enqueue (load latency 1).
  4. Otherwise rf_we=0 next cycle.
- Enqueue: an accepted load is pushed unless bypassed. Push and pop in the same cycle are legal; count is unchanged.
- Ordering:
  - FIFO entries pop strictly in arrival order.
  - When an ALU write is selected, every valid FIFO entry whose addr equals alu_wr_addr gets its kill bit set, so the older load never overwrites the younger result.
  - A load accepted in the same cycle as an ALU write to the same addr is enqueued unkilled, because the load is defined as younger.
- chk_pend=1 when chk_addr matches any valid unkilled FIFO entry, or (rf_we && rf_addr==chk_addr). The second term exists because the RF read port is registered and has no write bypass.
- fifo_cnt counts killed entries until they are popped.

Optional Feature:
RF_WB_FWD_EN
- Defined:
  - Adds outputs fwd_v (1) and fwd_data (DW).
  - fwd_v = rf_we && rf_addr==chk_addr, and fwd_data = rf_data when fwd_v, otherwise 0.
  - chk_pend drops the output-stage term; only FIFO matches count.
- Undefined: no fwd ports; chk_pend as specified above.

Decomposition:
- Package rf_wb_pkg holds:
  - constants AW, DW, TID_W=4, REG_W=5;
  - typedef wb_entry_t {addr, data, kill};
  - function rf_addr_f(tid, reg).
- One sub-module, rf_wb_fifo:
  - DEPTH entries, wrap-around rd/wr pointers plus count;
  - per-entry kill-by-address port;
  - parallel address-match output feeding chk_pend.

Test Plan:
- ALU write addr 0x012 data 0xDEADBEEF, FIFO empty -> next cycle rf_we=1, rf_addr=0x012, rf_data=0xDEADBEEF; fifo_cnt=0.
- ALU idle, FIFO empty, load addr 0x1E0 data 0x5 -> bypass: next cycle rf_we=1, rf_addr=0x1E0; fifo_cnt stays 0.
- ALU valid 8 consecutive cycles while loads 0x40..0x44 are offered each cycle -> 4 loads accepted; ld_wr_rdy=0 once full. After ALU idles, 0x40..0x43 are written in order on consecutive cycles, then 0x44 once ready returns.
- Queue load 0x021=0xAAAA behind an active ALU stream, then ALU write 0x021=0xBBBB -> entry is killed; its pop cycle has rf_we=0; the RF final value is 0xBBBB; chk_pend(0x021)=0 after the ALU write retires.
- Load 0x033 queued -> chk_pend(0x033)=1 until the cycle after its RF write. With RF_WB_FWD_EN, fwd_v=1 and fwd_data=load data in the output-stage cycle.
- 3 entries queued, rstn low 1 cycle -> fifo_cnt=0, no rf_we; ld_wr_rdy=0 during reset and 1 on the following cycle.
